// File: rtl/music_sequencer.sv
// Note-ROM melody sequencer: steps the ROM address at a fixed tempo and turns
// each word into a MIDI note, gate and attack strobe for the tone generator.
module music_sequencer #(
  parameter int TICKS_PER_STEP = 6250000,
  parameter int ADDR_W         = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_note,
  output logic [7:0]        note,
  output logic              gate,
  output logic              note_strobe,
  output logic [ADDR_W-1:0] play_addr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(TICKS_PER_STEP - 3);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [7:0]        note_q, note_d;
  logic              gate_q, gate_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  tick_q, tick_d;

  // Next-state and output decode; stop overrides whatever the state chose.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    paddr_d  = paddr_q;
    note_d   = note_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    tick_d   = tick_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          addr_d  = {ADDR_W{1'b0}};
          ovf_d   = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // An overflowed address is treated exactly like a fetched end marker.
        if (ovf_q || (rom_note == 8'd0)) begin
          ovf_d = 1'b0;
          if (loop_en) begin
            addr_d  = {ADDR_W{1'b0}};
            state_d = S_FETCH;
          end else begin
            note_d  = 8'd0;
            gate_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (rom_note == 8'd1) begin
          gate_d  = 1'b0;
          paddr_d = addr_q;
          tick_d  = {CNT_W{1'b0}};
          state_d = S_PLAY;
        end else if (gate_q && (note_q == rom_note)) begin
          paddr_d = addr_q;
          tick_d  = {CNT_W{1'b0}};
          state_d = S_PLAY;
        end else begin
          note_d   = rom_note;
          gate_d   = 1'b1;
          strobe_d = 1'b1;
          paddr_d  = addr_q;
          tick_d   = {CNT_W{1'b0}};
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_q == LAST_TICK) begin
          if (addr_q == LAST_ADDR) begin
            ovf_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
          state_d = S_FETCH;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      addr_d   = {ADDR_W{1'b0}};
      note_d   = 8'd0;
      gate_d   = 1'b0;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      ovf_d = ovf_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      paddr_q  <= {ADDR_W{1'b0}};
      note_q   <= 8'd0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tick_q   <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      paddr_q  <= paddr_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      tick_q   <= tick_d;
    end
  end

  assign rom_addr    = addr_q;
  assign play_addr   = paddr_q;
  assign note        = note_q;
  assign gate        = gate_q;
  assign note_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
